mux_rr_scheduler: RTL and testbench
===================================

# mux_rr_scheduler

Round-robin scheduler that shares the 16:1 bit-select datapath among 16 requesters. Each requester raises a request bit and presents its data bit on its lane. The scheduler drives the 4-bit select of an internal 16:1 mux and presents the selected bit on a valid/ready output port. It grants in bursts of up to `MAX_BURST` beats and rotates priority fairly.

## Interface
- `MAX_BURST`, default 4: maximum accepted beats per grant; legal range 1..15.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 16: per-requester request; `req[i]` belongs to lane i.
- `data_in` in 16: per-requester data bit; `data_in[15]` is the MSB lane.
- `out_ready` in 1: downstream ready.
- `out_valid` out 1: selected beat valid.
- `out_data` out 1: `data_in[sel]`.
- `sel` out 4: current grant index (mux select).
- `ack` out 16: one-hot; `ack[sel]` is high in the cycle a beat transfers.
- `busy` out 1: high while in GRANT.

## Operation
- States: IDLE, GRANT.
- Registers: `state`, `sel` (4b), `ptr` (4b, next priority start), `beat_cnt` (4b).
- Reset values: state=IDLE, sel=0, ptr=0, beat_cnt=0.
- Reset output values: out_valid=0, ack=0, busy=0, sel=0. `out_data` follows `data_in[0]`.
- In IDLE with `req`≠0:
  - Choose the first set bit scanning `ptr`, `ptr+1`, … mod 16, wrapping 15→0.
  - Load `sel` with that index, clear `beat_cnt`, go to GRANT.
- In IDLE with `req`=0: remain in IDLE; `sel` holds its value.
- GRANT outputs:
  - `out_valid` = `req[sel]`.
  - `out_data` = `data_in[sel]`, combinational through the internal 16:1 mux.
  - `busy`=1.
- Transfer condition: `out_valid && out_ready`. On a transfer, `ack` = one-hot(`sel`), combinational; otherwise `ack`=0.
- Release from GRANT occurs when either:
  - (a) a transfer happens with `beat_cnt`==`MAX_BURST`-1, or
  - (b) `req[sel]`=0 (requester withdrew; no transfer occurs that cycle).
- On release: `ptr` ← `sel`+1 mod 16, state ← IDLE, `beat_cnt` ← 0.
- Transfer without release: `beat_cnt` ← `beat_cnt`+1.
- Stall: while `out_ready`=0, hold `sel` and `beat_cnt` indefinitely; there is no timeout.
- Changes to other lanes' `req` during GRANT have no effect until re-arbitration.
- `sel` never changes while in GRANT.

## Timing
- Arbitration latency: `req` sampled high at edge t → `sel` updated and `out_valid`=1 in cycle t+1 (one cycle).
- Steady state: `MAX_BURST` beats per grant, then one IDLE (arbitration) cycle. With `MAX_BURST`=4 and `out_ready` stuck at 1, 4 beats occur per 5 cycles.
- `ack`, `out_valid` and `out_data` are combinational from state, `req`, `data_in` and `out_ready` (same-cycle).
- Simultaneous events:
  - Release and a new request in the same cycle: the new request waits for the IDLE cycle.
  - A released requester still requesting is scanned last in the next arbitration (`ptr` = `sel`+1).
- Reset mid-burst: outputs clear asynchronously on `rst_n` fall; `ack`=0 and `out_valid`=0 immediately. Partial burst is discarded; `ptr` returns to 0.

## Test plan
- Reset/idle:
  - Stimulus: `rst_n`=0, then release with `req`=0.
  - Required: `out_valid`=0, `ack`=0, `sel`=0, `busy`=0 for 10 cycles.
- Single requester burst:
  - Stimulus: `req`=16'h0020 held, `data_in[5]`=1, `out_ready`=1, `MAX_BURST`=4.
  - Required: `sel`=5; 4 transfers with `ack`=16'h0020; 1 IDLE cycle; regrant to 5.
- Round-robin wrap:
  - Stimulus: `req`=16'h8003 held, `ptr` starting at 0.
  - Required: grant order 0,1,15,0,1,…; each grant gets 4 beats.
- Backpressure:
  - Stimulus: `req`=16'h0100, `out_ready` toggled 1,0,0,1,1,0,1.
  - Required: `ack` only in ready cycles; `sel` stays 8; release after the 4th ack.
- Withdrawal:
  - Stimulus: `req[3]` dropped after 2 beats while `req[7]`=1.
  - Required: `out_valid`=0 that cycle, no ack; `sel`=7 two cycles later.
- Async reset mid-burst:
  - Stimulus: `rst_n` low during beat 2 of a lane-9 grant.
  - Required: `out_valid` and `ack` go to 0 without waiting for `clk`; after release, the first grant goes to the lowest requesting index from 0.

Source files
------------

// File: rtl/mux_rr_scheduler_if.sv
// Handshake bundle between the 16 requester lanes and the round-robin scheduler.
// The master side drives requests, data and downstream ready; the slave side is the scheduler.
interface mux_rr_scheduler_if;
  logic [15:0] req;
  logic [15:0] data_in;
  logic        out_ready;
  logic        out_valid;
  logic        out_data;
  logic [3:0]  sel;
  logic [15:0] ack;
  logic        busy;

  modport master (
    output req,
    output data_in,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  sel,
    input  ack,
    input  busy
  );

  modport slave (
    input  req,
    input  data_in,
    input  out_ready,
    output out_valid,
    output out_data,
    output sel,
    output ack,
    output busy
  );
endinterface

// File: rtl/mux_rr_scheduler.sv
// Round-robin burst scheduler sharing one 16:1 bit-select mux among 16 requesters.
// A grant lasts up to MAX_BURST accepted beats or until the granted lane drops its request.
module mux_rr_scheduler #(
  parameter int unsigned MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst_n,
  mux_rr_scheduler_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [3:0] LastBeat = 4'(MAX_BURST - 1);

  state_e     state_q;
  logic [3:0] sel_q;
  logic [3:0] ptr_q;
  logic [3:0] beat_cnt_q;
  logic [3:0] pick;
  logic [3:0] idx;
  logic       in_grant;
  logic       xfer;
  logic       release_grant;

  // Scan offsets high to low so the lane closest to ptr_q is the one left in pick.
  always_comb begin
    pick = ptr_q;
    idx  = ptr_q;
    for (int i = 15; i >= 0; i--) begin
      idx = ptr_q + 4'(i);
      if (bus.req[idx]) begin
        pick = idx;
      end
    end
  end

  assign in_grant      = (state_q == StGrant);
  assign bus.out_valid = in_grant && bus.req[sel_q];
  assign bus.out_data  = bus.data_in[sel_q];
  assign bus.sel       = sel_q;
  assign bus.busy      = in_grant;
  assign xfer          = bus.out_valid && bus.out_ready;
  assign bus.ack       = xfer ? (16'h0001 << sel_q) : 16'h0000;

  // A withdrawn request ends the grant even though no beat moves that cycle.
  assign release_grant = !bus.req[sel_q] || (xfer && (beat_cnt_q == LastBeat));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= 4'd0;
      ptr_q      <= 4'd0;
      beat_cnt_q <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|bus.req) begin
            sel_q      <= pick;
            beat_cnt_q <= 4'd0;
            state_q    <= StGrant;
          end
        end
        StGrant: begin
          if (release_grant) begin
            ptr_q      <= sel_q + 4'd1;
            beat_cnt_q <= 4'd0;
            state_q    <= StIdle;
          end else if (xfer) begin
            beat_cnt_q <= beat_cnt_q + 4'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler: expected beats are queued as stimulus is issued
// and a negedge monitor pops one entry per observed transfer.
module tb_mux_rr_scheduler;

  typedef struct {
    logic [3:0] sel;
    logic       data;
  } beat_t;

  logic  clk;
  logic  rst_n;
  int    checks;
  int    failures;
  beat_t exp_q[$];

  mux_rr_scheduler_if bus ();

  mux_rr_scheduler #(
    .MAX_BURST(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] s, input logic d, input int n);
    beat_t b;
    b.sel  = s;
    b.data = d;
    for (int i = 0; i < n; i++) exp_q.push_back(b);
  endtask

  // One clock cycle: sample at negedge against expected busy/sel/valid, return at posedge+1.
  task automatic cyc(input logic eb, input logic [3:0] es, input logic ev);
    logic [15:0] ea;
    @(negedge clk);
    ea = (ev && bus.out_ready) ? (16'h0001 << es) : 16'h0000;
    chk("busy", 32'(bus.busy), 32'(eb));
    chk("sel", 32'(bus.sel), 32'(es));
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("ack", 32'(bus.ack), 32'(ea));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req       = 16'h0000;
    bus.data_in   = 16'h0000;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    beat_t e;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_xfer: got sel %0d expected no transfer at %0t", bus.sel, $time);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_sel", 32'(bus.sel), 32'(e.sel));
        chk("xfer_data", 32'(bus.out_data), 32'(e.data));
        chk("xfer_ack", 32'(bus.ack), 32'(16'h0001 << e.sel));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] rr_lane[4];
    logic       rr_data[4];
    logic       bp_ready[7];
    logic [3:0] prev;
    checks   = 0;
    failures = 0;

    // Reset and idle with no requests.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b0, 4'd0, 1'b0);

    // Single requester on lane 5: two full bursts separated by one arbitration cycle.
    bus.req       = 16'h0020;
    bus.data_in   = 16'h0020;
    bus.out_ready = 1'b1;
    push(4'd5, 1'b1, 8);
    cyc(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'd5, 1'b1);
    cyc(1'b0, 4'd5, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'd5, 1'b1);
    bus.req = 16'h0000;
    cyc(1'b0, 4'd5, 1'b0);

    // Round-robin wrap over lanes 0, 1, 15 starting from ptr 0.
    do_reset();
    rr_lane       = '{4'd0, 4'd1, 4'd15, 4'd0};
    rr_data       = '{1'b0, 1'b1, 1'b1, 1'b0};
    bus.req       = 16'h8003;
    bus.data_in   = 16'h8002;
    bus.out_ready = 1'b1;
    prev          = 4'd0;
    for (int g = 0; g < 4; g++) push(rr_lane[g], rr_data[g], 4);
    for (int g = 0; g < 4; g++) begin
      cyc(1'b0, prev, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, rr_lane[g], 1'b1);
      prev = rr_lane[g];
    end
    bus.req = 16'h0000;
    cyc(1'b0, 4'd0, 1'b0);

    // Backpressure on lane 8: acks only in ready cycles, release after the 4th.
    bp_ready    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bus.req     = 16'h0100;
    bus.data_in = 16'h0100;
    push(4'd8, 1'b1, 4);
    cyc(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      bus.out_ready = bp_ready[i];
      cyc(1'b1, 4'd8, 1'b1);
    end
    bus.req       = 16'h0000;
    bus.out_ready = 1'b1;
    cyc(1'b0, 4'd8, 1'b0);

    // Withdrawal: lane 3 drops after 2 beats, lane 7 is granted two cycles later.
    bus.req     = 16'h0088;
    bus.data_in = 16'h0008;
    push(4'd3, 1'b1, 2);
    push(4'd7, 1'b0, 4);
    cyc(1'b0, 4'd8, 1'b0);
    cyc(1'b1, 4'd3, 1'b1);
    cyc(1'b1, 4'd3, 1'b1);
    bus.req = 16'h0080;
    cyc(1'b1, 4'd3, 1'b0);
    cyc(1'b0, 4'd3, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'd7, 1'b1);
    bus.req = 16'h0000;
    cyc(1'b0, 4'd7, 1'b0);

    // Async reset during beat 2 of a lane-9 grant; afterwards the scan restarts at 0.
    bus.req     = 16'h1204;
    bus.data_in = 16'h0200;
    push(4'd9, 1'b1, 2);
    cyc(1'b0, 4'd7, 1'b0);
    cyc(1'b1, 4'd9, 1'b1);
    cyc(1'b1, 4'd9, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(4'd2, 1'b0, 4);
    cyc(1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'd2, 1'b1);
    bus.req = 16'h0000;
    cyc(1'b0, 4'd2, 1'b0);

    repeat (3) cyc(1'b0, 4'd2, 1'b0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
